// File: rtl/sprite_pkg.sv
// Shared constants and state encoding for the sprite blitter.
package sprite_pkg;
  localparam int unsigned SPR_W    = 28;
  localparam int unsigned SPR_H    = 30;
  localparam int unsigned SPR_N    = SPR_W * SPR_H;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COL_W    = 5;
  localparam int unsigned ROW_W    = 5;

  localparam int unsigned OPAQUE_BIT   = 0;
  localparam int unsigned COLOUR_LSB   = 1;
  localparam int unsigned COLOUR_MSB   = 3;
  localparam int unsigned COLOUR_W     = COLOUR_MSB - COLOUR_LSB + 1;
  localparam int unsigned DRAIN_CYCLES = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_e;
endpackage

// File: rtl/sprite_addr_gen.sv
// Raster-order column/row/address counters for walking the sprite memory.
module sprite_addr_gen
  import sprite_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  // Address runs alongside col/row so no row*SPR_W multiply is needed.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
      last <= 1'b0;
    end else if (advance) begin
      if (col == COL_W'(SPR_W - 1)) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
      addr <= addr + ADDR_W'(1);
      last <= (addr == ADDR_W'(SPR_N - 2));
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Streams every sprite word from memory and turns opaque on-screen pixels into VGA plots.
module sprite_blitter
  import sprite_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   addr_read,
  input  logic [DATA_W-1:0]   pix_in,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  state_e           state;
  logic             drain_cnt;
  logic [X_W-1:0]   x0_q;
  logic [Y_W-1:0]   y0_q;
  logic             accept;
  logic             advance;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             last;

  logic             s1_valid;
  logic [COL_W-1:0] s1_col;
  logic [ROW_W-1:0] s1_row;
  logic [X_W:0]     sum_x;
  logic [Y_W:0]     sum_y;
  logic             on_screen;
  logic             unused_pix_bits;

  assign accept  = (state == IDLE) && start;
  assign advance = (state == FETCH) && !last;

  sprite_addr_gen u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .advance (advance),
    .col     (col),
    .row     (row),
    .addr    (addr_read),
    .last    (last)
  );

  // Control FSM; busy/done are registered alongside the state transitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= 1'b0;
      x0_q      <= '0;
      y0_q      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            busy  <= 1'b1;
            x0_q  <= x0;
            y0_q  <= y0;
          end
        end
        FETCH: begin
          if (last) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt == 1'(DRAIN_CYCLES - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Sums carry one extra bit so off-screen positions are detected before truncation.
  assign sum_x     = {1'b0, x0_q} + (X_W + 1)'(s1_col);
  assign sum_y     = {1'b0, y0_q} + (Y_W + 1)'(s1_row);
  assign on_screen = (sum_x < (X_W + 1)'(SCREEN_W)) && (sum_y < (Y_W + 1)'(SCREEN_H));
  assign unused_pix_bits = ^pix_in[DATA_W-1:COLOUR_MSB+1];

  // Stage 1 aligns col/row with the memory read; stage 2 registers the plot.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_col     <= '0;
      s1_row     <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      s1_valid <= (state == FETCH);
      s1_col   <= col;
      s1_row   <= row;
      vga_plot <= s1_valid && pix_in[OPAQUE_BIT] && on_screen;
      if (s1_valid) begin
        vga_x      <= sum_x[X_W-1:0];
        vga_y      <= sum_y[Y_W-1:0];
        vga_colour <= pix_in[COLOUR_MSB:COLOUR_LSB];
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a cycle-accurate reference of the draw timeline.
module tb_sprite_blitter;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  x0;
  logic [6:0]  y0;
  logic        busy;
  logic        done;
  logic [9:0]  addr_read;
  logic [15:0] pix_in;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  sprite_blitter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x0         (x0),
    .y0         (y0),
    .busy       (busy),
    .done       (done),
    .addr_read  (addr_read),
    .pix_in     (pix_in),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  // Sprite memory: 840 words, one-cycle registered read.
  logic [15:0] mem [0:839];
  always @(posedge clk) pix_in <= mem[addr_read];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  bit act = 0;
  int t0 = 0, xm = 0, ym = 0;
  int nplots = 0, done_d = -1, fx = -1, fy = -1, lx = -1, ly = -1, lcol = -1;
  bit seen = 0;

  task automatic check(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference: outputs derived from the draw start cycle, latched origin and memory contents.
  always @(negedge clk) begin
    int d, k, col, row;
    logic [15:0] pix;
    bit eplot;
    if (chk_en) begin
      d = cyc - t0;
      eplot = 0;
      check("busy", busy, (act && d >= 1 && d <= 842) ? 1 : 0);
      check("done", done, (act && d == 843) ? 1 : 0);
      if (act && d >= 1 && d <= 840) check("addr_read", addr_read, d - 1);
      if (act && d >= 3 && d <= 842) begin
        k   = d - 3;
        col = k % 28;
        row = k / 28;
        pix = mem[k];
        eplot = pix[0] && (xm + col < 160) && (ym + row < 120);
        check("vga_x", vga_x, (xm + col) % 256);
        check("vga_y", vga_y, (ym + row) % 128);
        check("vga_colour", vga_colour, pix[3:1]);
      end
      check("vga_plot", vga_plot, eplot ? 1 : 0);
      if (vga_plot) begin
        if (!seen) begin
          fx = vga_x;
          fy = vga_y;
          seen = 1;
        end
        lx = vga_x;
        ly = vga_y;
        lcol = vga_colour;
        nplots++;
      end
      if (done) done_d = d;
    end
  end

  task automatic fill(input int mode);
    for (int k = 0; k < 840; k++) begin
      case (mode)
        0:       mem[k] = 16'h000B;
        1:       mem[k] = {12'hF0F, 3'(k % 8), 1'(k % 2)};
        default: mem[k] = {12'hA5A, 3'((k / 7) % 8), 1'b1};
      endcase
    end
  endtask

  // Called right after a posedge; marks the current cycle as the accept cycle.
  task automatic begin_draw(input int xs, input int ys);
    start = 1'b1;
    x0 = 8'(xs);
    y0 = 7'(ys);
    t0 = cyc;
    xm = xs;
    ym = ys;
    act = 1;
    nplots = 0;
    done_d = -1;
    seen = 0;
  endtask

  task automatic start_draw(input int xs, input int ys);
    @(posedge clk); #1;
    begin_draw(xs, ys);
    @(posedge clk); #1;
    start = 1'b0;
    x0 = x0 + 8'd77;
    y0 = y0 + 7'd33;
  endtask

  task automatic wait_end(input string nm, input int exp_plots);
    repeat (844) @(posedge clk);
    #1;
    check({nm, "_plots"}, nplots, exp_plots);
    check({nm, "_done_cycle"}, done_d, 843);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    x0 = 8'd0;
    y0 = 7'd0;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", addr_read, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    check("rst_plot", vga_plot, 0);
    reset = 1'b0;
    start = 1'b0;
    chk_en = 1;
    repeat (5) @(posedge clk);

    // Full opaque draw
    fill(0);
    start_draw(10, 20);
    wait_end("opaque", 840);
    check("opaque_first_x", fx, 10);
    check("opaque_first_y", fy, 20);
    check("opaque_last_x", lx, 37);
    check("opaque_last_y", ly, 49);
    check("opaque_colour", lcol, 5);

    // Transparency: odd addresses only
    fill(1);
    start_draw(40, 30);
    wait_end("transp", 420);

    // Clipping at the bottom-right corner
    fill(2);
    start_draw(150, 100);
    wait_end("clip", 200);
    check("clip_last_x", lx, 159);
    check("clip_last_y", ly, 119);

    // Ignored starts at cycles 100 and 843, accepted at 844
    fill(2);
    start_draw(0, 0);
    repeat (99) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (742) @(posedge clk);
    #1;
    start = 1'b1;
    x0 = 8'd5;
    y0 = 7'd5;
    @(posedge clk); #1;
    check("b2b_first_plots", nplots, 840);
    check("b2b_first_done", done_d, 843);
    begin_draw(5, 5);
    @(posedge clk); #1 start = 1'b0;
    repeat (844) @(posedge clk);
    #1;
    check("b2b_second_plots", nplots, 840);
    check("b2b_second_done", done_d, 843);
    check("b2b_second_first_x", fx, 5);

    // Reset mid-draw at cycle 400
    fill(0);
    start_draw(10, 20);
    repeat (399) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    act = 0;
    check("midrst_busy", busy, 0);
    check("midrst_plot", vga_plot, 0);
    check("midrst_done", done, 0);
    check("midrst_addr", addr_read, 0);
    check("midrst_x", vga_x, 0);
    check("midrst_y", vga_y, 0);
    check("midrst_colour", vga_colour, 0);
    done_d = -1;
    repeat (500) @(posedge clk);
    #1;
    check("midrst_no_done", done_d, -1);

    // Redraw after the aborted draw
    fill(1);
    start_draw(30, 40);
    wait_end("redraw", 420);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
